aes256_key_expand: RTL and testbench

- Iterative AES-256 key schedule (FIPS-197) that turns a 256-bit cipher key into the 15 128-bit round keys (RK0..RK14) used by the round-key XOR stages of the encryption pipeline.
- Streams one round key per cycle with index and valid for stages loading keys on the fly.
- Also holds all 15 keys in an internal store with a registered read port for stages that fetch by round number.
- Sits directly upstream of the add-round-key stages.

---
 rtl/aes256_key_expand.sv | 157 +++++++++++++++
 tb/tb_aes256_key_expand.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: streams RK0..RK14 one per cycle and keeps them in a
// small store with a registered read port. Bit 0 of every key bus is the MSB
// of byte 0, so key data is bit-reversed into MSB-first form for the word
// arithmetic and reversed back on the way out.
module aes256_key_expand #(
  parameter int NR = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key_in,
  input  logic         key_valid,
  output logic         busy,
  output logic [127:0] round_key,
  output logic [3:0]   round_key_idx,
  output logic         round_key_valid,
  output logic         keys_ready,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] GEN      = 1'b1;
  localparam logic [3:0] LAST_IDX = 4'(NR);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [0:0]   state;
  logic [3:0]   counter;
  logic         finished;
  logic [127:0] prev_grp;
  logic [127:0] cur_grp;
  logic [255:0] key_msb;
  logic [31:0]  last_w;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic [7:0]   rcon;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] new_grp;
  logic [127:0] emit_msb;
  logic [127:0] emit_bus;
  logic [127:0] store [NR+1];

  assign busy = round_key_valid;

  // Reorder the incoming key into MSB-first form (bit 255 = MSB of byte 0).
  always_comb begin
    key_msb = '0;
    for (int unsigned i = 0; i < 256; i++) key_msb[i] = key_in[255-i];
  end

  // Next four schedule words from the two previous groups.
  always_comb begin
    last_w  = cur_grp[31:0];
    rot_w   = counter[0] ? last_w : {last_w[23:0], last_w[31:24]};
    sub_w   = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
    rcon    = 8'h01 << (counter[3:1] - 3'd1);
    temp_w  = counter[0] ? sub_w : (sub_w ^ {rcon, 24'h0});
    n0      = prev_grp[127:96] ^ temp_w;
    n1      = prev_grp[95:64]  ^ n0;
    n2      = prev_grp[63:32]  ^ n1;
    n3      = prev_grp[31:0]   ^ n2;
    new_grp = {n0, n1, n2, n3};
  end

  // Select the key for this cycle and map it back to the bus bit order.
  always_comb begin
    if (counter == 4'd0)      emit_msb = prev_grp;
    else if (counter == 4'd1) emit_msb = cur_grp;
    else                      emit_msb = new_grp;
    emit_bus = '0;
    for (int unsigned i = 0; i < 128; i++) emit_bus[i] = emit_msb[127-i];
  end

  // Control FSM and streamed outputs.
  // keys_ready is cleared on the first GEN cycle rather than at the load edge,
  // so a load in the first idle cycle still shows keys_ready for that cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      counter         <= '0;
      finished        <= 1'b0;
      keys_ready      <= 1'b0;
      round_key_valid <= 1'b0;
      round_key_idx   <= '0;
      round_key       <= '0;
    end else begin
      round_key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (finished) begin
            keys_ready <= 1'b1;
            finished   <= 1'b0;
          end
          if (key_valid) begin
            counter <= '0;
            state   <= GEN;
          end
        end
        GEN: begin
          round_key       <= emit_bus;
          round_key_idx   <= counter;
          round_key_valid <= 1'b1;
          if (counter == 4'd0) keys_ready <= 1'b0;
          if (counter == LAST_IDX) begin
            state    <= IDLE;
            finished <= 1'b1;
          end else begin
            counter <= counter + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Working register: the two most recent word groups.
  always_ff @(posedge clk) begin
    if (state == IDLE && key_valid) begin
      prev_grp <= key_msb[255:128];
      cur_grp  <= key_msb[127:0];
    end else if (state == GEN && counter >= 4'd2) begin
      prev_grp <= cur_grp;
      cur_grp  <= new_grp;
    end
  end

  // Key store, written alongside the stream.
  always_ff @(posedge clk) begin
    if (reset && state == GEN) store[counter] <= emit_bus;
  end

  // Registered read port; indices past the last round read as zero.
  always_ff @(posedge clk) begin
    if (!reset)                  rd_key <= '0;
    else if (rd_idx <= LAST_IDX) rd_key <= store[rd_idx];
    else                         rd_key <= '0;
  end

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand with a queue-based stream scoreboard.
module tb_aes256_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key_in;
  logic         key_valid;
  logic         busy;
  logic [127:0] round_key;
  logic [3:0]   round_key_idx;
  logic         round_key_valid;
  logic         keys_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  logic [127:0] model_rk [15];
  logic [127:0] cap [15];

  localparam logic [255:0] KEY_A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_Z = '0;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  aes256_key_expand #(.NR(14)) dut (
    .clk            (clk),
    .reset          (reset),
    .key_in         (key_in),
    .key_valid      (key_valid),
    .busy           (busy),
    .round_key      (round_key),
    .round_key_idx  (round_key_idx),
    .round_key_valid(round_key_valid),
    .keys_ready     (keys_ready),
    .rd_idx         (rd_idx),
    .rd_key         (rd_key)
  );

  always #5 clk = ~clk;

  // Bus order has bit 0 as the MSB of byte 0; hex constants are MSB-first.
  function automatic logic [255:0] rev256(input logic [255:0] v);
    logic [255:0] r;
    for (int i = 0; i < 256; i++) r[i] = v[255-i];
    return r;
  endfunction

  function automatic logic [127:0] rev128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = v[127-i];
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Word-indexed FIPS-197 expansion into model_rk (MSB-first).
  task automatic gen_model(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_expected(input logic [255:0] k);
    exp_t e;
    gen_model(k);
    for (int r = 0; r < 15; r++) begin
      e.idx = 4'(r);
      e.key = rev128(model_rk[r]);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every valid beat is matched against the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (round_key_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual_idx=%0d expected=none", round_key_idx);
      end else begin
        e = exp_q.pop_front();
        chk("stream_idx", 128'(round_key_idx), 128'(e.idx));
        chk("stream_key", round_key, e.key);
        if (round_key_idx < 4'd15) cap[round_key_idx] = rev128(round_key);
      end
    end
  end

  // Issue one load and walk the 16 cycles after the load edge T.
  task automatic run_load(input logic [255:0] k, input logic [255:0] junk,
                          input int pulse_a, input int pulse_b, input int reset_at,
                          input bit chain, input logic [255:0] next_k, input bit pre_driven);
    if (!pre_driven) begin
      key_in    = rev256(k);
      key_valid = 1'b1;
      push_expected(k);
      @(negedge clk);
    end
    key_valid = 1'b0;
    key_in    = rev256(junk);
    for (int c = 1; c <= 16; c++) begin
      key_valid = (c == pulse_a || c == pulse_b);
      if (reset_at != 0 && c == reset_at)     reset = 1'b0;
      if (reset_at != 0 && c == reset_at + 2) reset = 1'b1;
      if (chain && c == 16) begin
        key_in    = rev256(next_k);
        key_valid = 1'b1;
        push_expected(next_k);
      end
      @(negedge clk);
      if (reset_at != 0 && c >= reset_at) begin
        chk("abort_valid", 128'(round_key_valid), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_ready", 128'(keys_ready), 128'(0));
        if (c == reset_at) begin
          chk("abort_rk", round_key, '0);
          chk("abort_idx", 128'(round_key_idx), 128'(0));
        end
      end else begin
        chk($sformatf("valid_T%0d", c), 128'(round_key_valid), 128'(c <= 15));
        chk($sformatf("busy_T%0d", c), 128'(busy), 128'(c <= 15));
        chk($sformatf("ready_T%0d", c), 128'(keys_ready), 128'(c == 16));
      end
    end
    if (!chain) key_valid = 1'b0;
  endtask

  task automatic sweep_store();
    for (int i = 0; i <= 15; i++) begin
      rd_idx = 4'(i);
      @(negedge clk);
      chk($sformatf("rd_key_%0d", i), rd_key, (i < 15) ? rev128(model_rk[i]) : 128'h0);
    end
  endtask

  initial begin
    int pulses;
    reset     = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rd_idx    = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(round_key_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_ready", 128'(keys_ready), 128'(0));
    chk("rst_idx", 128'(round_key_idx), 128'(0));
    chk("rst_rk", round_key, '0);
    chk("rst_rd_key", rd_key, '0);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (round_key_valid || busy || keys_ready) pulses++;
    end
    chk("idle_activity", 128'(pulses), 128'(0));
    chk("idle_rk", round_key, '0);

    // FIPS-197 A.3 key
    run_load(KEY_A, KEY_B, 0, 0, 0, 1'b0, KEY_Z, 1'b0);
    chk("a3_idx0", cap[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("a3_idx1", cap[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("a3_idx2", cap[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a3_idx14", cap[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("a3_hold", rev128(round_key), 128'hfe4890d1e6188d0b046df344706c631e);
    sweep_store();

    // Loads while busy (incl. the idx14 cycle) are dropped
    run_load(KEY_A, KEY_B, 5, 15, 0, 1'b0, KEY_Z, 1'b0);
    repeat (4) @(negedge clk);
    chk("ignored_ready", 128'(keys_ready), 128'(1));
    chk("ignored_busy", 128'(busy), 128'(0));
    sweep_store();

    // Reset mid-generation, then the all-zero key
    run_load(KEY_A, KEY_B, 0, 0, 8, 1'b0, KEY_Z, 1'b0);
    chk("abort_leftover", 128'(exp_q.size()), 128'(8));
    exp_q.delete();
    repeat (2) @(negedge clk);
    run_load(KEY_Z, KEY_B, 0, 0, 0, 1'b0, KEY_Z, 1'b0);
    chk("zero_idx2", cap[2], 128'h62636363626363636263636362636363);

    // Back-to-back: second load in the first idle cycle
    run_load(KEY_A, KEY_B, 0, 0, 0, 1'b1, KEY_B, 1'b0);
    run_load(KEY_B, KEY_Z, 0, 0, 0, 1'b0, KEY_Z, 1'b1);
    sweep_store();
    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
